// File: rtl/regfile_writeback_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs drained round-robin into a
// registered register-file write port, with a pending-write mask for hazard logic.
module regfile_writeback_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [4:0]            mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  write_enable,
  output logic [4:0]            write_destination,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [31:0]           pending_mask
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned NSRC = 2;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic [4:0]            ent_rd_q   [NSRC][DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_q [NSRC][DEPTH];
  logic [AW-1:0]         wptr_q     [NSRC];
  logic [AW-1:0]         rptr_q     [NSRC];
  logic [CW-1:0]         cnt_q      [NSRC];

  logic [NSRC-1:0]       in_valid;
  logic [NSRC-1:0]       ready;
  logic [NSRC-1:0]       push;
  logic [NSRC-1:0]       pop;
  logic [NSRC-1:0]       nonempty;
  logic [4:0]            in_rd      [NSRC];
  logic [DATA_WIDTH-1:0] in_data    [NSRC];

  src_e                  last_q, last_d, sel;
  logic                  grant;
  logic [4:0]            head_rd;
  logic [DATA_WIDTH-1:0] head_data;

  logic                  we_q, we_d;
  logic [4:0]            dest_q, dest_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           pend;

  // Index 0 is the ALU source, index 1 the MEM source.
  always_comb begin
    in_valid   = {mem_valid, alu_valid};
    in_rd[0]   = alu_rd;
    in_rd[1]   = mem_rd;
    in_data[0] = alu_data;
    in_data[1] = mem_data;
    for (int unsigned s = 0; s < NSRC; s++) begin
      ready[s]    = reset && (cnt_q[s] != CW'(DEPTH));
      push[s]     = in_valid[s] && ready[s];
      nonempty[s] = (cnt_q[s] != '0);
    end
  end

  assign alu_ready = ready[0];
  assign mem_ready = ready[1];

  always_comb begin
    sel   = SRC_ALU;
    grant = 1'b0;
    if (nonempty[0] && nonempty[1]) begin
      grant = 1'b1;
      sel   = (last_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end else if (nonempty[0]) begin
      grant = 1'b1;
      sel   = SRC_ALU;
    end else if (nonempty[1]) begin
      grant = 1'b1;
      sel   = SRC_MEM;
    end
    if (!reset) begin
      grant = 1'b0;
    end

    pop       = '0;
    head_rd   = (sel == SRC_MEM) ? ent_rd_q[1][rptr_q[1]]   : ent_rd_q[0][rptr_q[0]];
    head_data = (sel == SRC_MEM) ? ent_data_q[1][rptr_q[1]] : ent_data_q[0][rptr_q[0]];
    last_d    = last_q;
    we_d      = 1'b0;
    dest_d    = dest_q;
    data_d    = data_q;
    if (grant) begin
      pop    = {sel == SRC_MEM, sel == SRC_ALU};
      last_d = sel;
      // x0 writes still consume the slot but never reach the register file.
      we_d   = (head_rd != '0);
      dest_d = head_rd;
      data_d = head_data;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (push[s]) begin
        ent_rd_q[s][wptr_q[s]]   <= in_rd[s];
        ent_data_q[s][wptr_q[s]] <= in_data[s];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      last_q <= SRC_MEM;
      we_q   <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (push[s]) begin
          wptr_q[s] <= wptr_q[s] + AW'(1);
        end
        if (pop[s]) begin
          rptr_q[s] <= rptr_q[s] + AW'(1);
        end
        cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
      last_q <= last_d;
      we_q   <= we_d;
      dest_q <= dest_d;
      data_q <= data_d;
    end
  end

  // Walk only the occupied slots of each FIFO, starting at its read pointer.
  always_comb begin
    pend = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (CW'(k) < cnt_q[s]) begin
          pend[ent_rd_q[s][rptr_q[s] + AW'(k)]] = 1'b1;
        end
      end
    end
    if (we_q) begin
      pend[dest_q] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign write_enable      = we_q;
  assign write_destination = dest_q;
  assign write_data        = data_q;
  assign pending_mask      = pend;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: accepted pushes are queued per
// source and matched against every write the port presents.
module tb_regfile_writeback_arbiter;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        write_enable;
  logic [4:0]  write_destination;
  logic [31:0] write_data;
  logic [31:0] pending_mask;

  regfile_writeback_arbiter #(
    .DEPTH      (2),
    .DATA_WIDTH (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .alu_valid         (alu_valid),
    .alu_ready         (alu_ready),
    .alu_rd            (alu_rd),
    .alu_data          (alu_data),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_rd            (mem_rd),
    .mem_data          (mem_data),
    .write_enable      (write_enable),
    .write_destination (write_destination),
    .write_data        (write_data),
    .pending_mask      (pending_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [36:0] alu_exp[$];
  logic [36:0] mem_exp[$];
  logic [4:0]  order_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Record accepted pushes (pre-edge handshake values); reset discards them.
  always @(posedge clock) begin
    if (!reset) begin
      alu_exp.delete();
      mem_exp.delete();
    end else begin
      if (alu_valid && alu_ready && alu_rd != 5'd0) alu_exp.push_back({alu_rd, alu_data});
      if (mem_valid && mem_ready && mem_rd != 5'd0) mem_exp.push_back({mem_rd, mem_data});
    end
  end

  always @(negedge clock) begin
    if (write_enable === 1'b1) begin
      order_log.push_back(write_destination);
      if (alu_exp.size() > 0 && alu_exp[0][36:32] == write_destination) begin
        check("wb_alu", {27'd0, write_destination, write_data}, {27'd0, alu_exp.pop_front()});
      end else if (mem_exp.size() > 0) begin
        check("wb_mem", {27'd0, write_destination, write_data}, {27'd0, mem_exp.pop_front()});
      end else begin
        check("wb_spurious", {63'd0, write_enable}, 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic send_alu(input logic [4:0] rd, input logic [31:0] d);
    logic acc;
    acc       = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clock);
      acc = alu_ready;
      @(negedge clock);
    end
    alu_valid = 1'b0;
    check("alu_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_mem(input logic [4:0] rd, input logic [31:0] d);
    logic acc;
    acc       = 1'b0;
    mem_valid = 1'b1;
    mem_rd    = rd;
    mem_data  = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clock);
      acc = mem_ready;
      @(negedge clock);
    end
    mem_valid = 1'b0;
    check("mem_accept", {63'd0, acc}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int exp_order[6];

  initial begin
    exp_order = '{1, 10, 2, 11, 3, 12};
    reset     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;

    // Reset state
    repeat (2) begin
      @(negedge clock);
      check("rst_we",   {63'd0, write_enable}, 64'd0);
      check("rst_dest", {59'd0, write_destination}, 64'd0);
      check("rst_data", {32'd0, write_data}, 64'd0);
      check("rst_pend", {32'd0, pending_mask}, 64'd0);
      check("rst_ardy", {63'd0, alu_ready}, 64'd0);
      check("rst_mrdy", {63'd0, mem_ready}, 64'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ardy", {63'd0, alu_ready}, 64'd1);
    check("post_rst_mrdy", {63'd0, mem_ready}, 64'd1);
    check("post_rst_we",   {63'd0, write_enable}, 64'd0);

    // Single ALU write, one-cycle write_enable pulse
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    @(negedge clock);
    alu_valid = 1'b0;
    check("single_we_n",   {63'd0, write_enable}, 64'd0);
    check("single_pend_n", {32'd0, pending_mask}, 64'h20);
    @(negedge clock);
    check("single_we",   {63'd0, write_enable}, 64'd1);
    check("single_dest", {59'd0, write_destination}, 64'd5);
    check("single_data", {32'd0, write_data}, 64'hDEADBEEF);
    check("single_pend", {32'd0, pending_mask}, 64'h20);
    @(negedge clock);
    check("single_we_off",   {63'd0, write_enable}, 64'd0);
    check("single_pend_off", {32'd0, pending_mask}, 64'd0);

    // Contention: strict alternation starting with ALU
    do_reset();
    order_log.delete();
    fork
      begin
        send_alu(5'd1, 32'hA000_0001);
        send_alu(5'd2, 32'hA000_0002);
        send_alu(5'd3, 32'hA000_0003);
      end
      begin
        send_mem(5'd10, 32'hB000_000A);
        send_mem(5'd11, 32'hB000_000B);
        send_mem(5'd12, 32'hB000_000C);
      end
    join
    idle(8);
    check("order_len", order_log.size(), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < order_log.size()) check($sformatf("order%0d", i), {59'd0, order_log[i]}, exp_order[i]);
    end

    // Full ALU FIFO: ready drops, a held valid waits for a freed slot
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA000_0014;
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'hB000_0015;
    @(negedge clock);
    check("fill_ardy1", {63'd0, alu_ready}, 64'd1);
    check("fill_mrdy1", {63'd0, mem_ready}, 64'd1);
    alu_rd = 5'd22; alu_data = 32'hA000_0016;
    mem_rd = 5'd23; mem_data = 32'hB000_0017;
    @(negedge clock);
    check("fill_mrdy_full", {63'd0, mem_ready}, 64'd0);
    check("fill_ardy2",     {63'd0, alu_ready}, 64'd1);
    check("fill_we20",      {58'd0, write_enable, write_destination}, {58'd0, 1'b1, 5'd20});
    alu_rd = 5'd24; alu_data = 32'hA000_0018;
    mem_valid = 1'b0;
    @(negedge clock);
    check("fill_ardy_full", {63'd0, alu_ready}, 64'd0);
    check("fill_mrdy3",     {63'd0, mem_ready}, 64'd1);
    alu_rd = 5'd26; alu_data = 32'hA000_001A;
    @(negedge clock);
    check("fill_ardy_freed", {63'd0, alu_ready}, 64'd1);
    check("fill_no_passthru", {63'd0, pending_mask[26]}, 64'd0);
    check("fill_we22", {58'd0, write_enable, write_destination}, {58'd0, 1'b1, 5'd22});
    @(negedge clock);
    check("fill_third_in", {63'd0, pending_mask[26]}, 64'd1);
    alu_valid = 1'b0;
    idle(6);

    // x0 write: accepted and popped, never written, never pending
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    repeat (5) begin
      @(negedge clock);
      alu_valid = 1'b0;
      check("x0_we",    {63'd0, write_enable}, 64'd0);
      check("x0_pend0", {63'd0, pending_mask[0]}, 64'd0);
      check("x0_pend",  {32'd0, pending_mask}, 64'd0);
    end
    check("x0_ardy", {63'd0, alu_ready}, 64'd1);

    // Reset mid-stream discards buffered and in-flight writes
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd7;  alu_data = 32'hA000_0007;
    mem_valid = 1'b1; mem_rd = 5'd17; mem_data = 32'hB000_0011;
    @(negedge clock);
    alu_rd = 5'd8;  alu_data = 32'hA000_0008;
    mem_rd = 5'd18; mem_data = 32'hB000_0012;
    @(negedge clock);
    alu_rd = 5'd9;  alu_data = 32'hA000_0009;
    mem_valid = 1'b0;
    @(negedge clock);
    alu_valid = 1'b0;
    check("mid_pend", {32'd0, pending_mask}, {32'd0, 32'h0006_0300});
    check("mid_we17", {58'd0, write_enable, write_destination}, {58'd0, 1'b1, 5'd17});
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("midrst_we",   {63'd0, write_enable}, 64'd0);
      check("midrst_pend", {32'd0, pending_mask}, 64'd0);
      check("midrst_ardy", {63'd0, alu_ready}, 64'd0);
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("after_rst_we",   {63'd0, write_enable}, 64'd0);
      check("after_rst_pend", {32'd0, pending_mask}, 64'd0);
    end

    check("sb_empty", alu_exp.size() + mem_exp.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
